// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module   : pipeline_pkg
// Brief    : Shared MEM->WB bundle definition and default field widths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

    localparam int c_NB_DATA  = 32;
    localparam int c_NB_REG   = 5;
    localparam int c_NB_PC    = 32;
    localparam int c_REG_LINK = 31;

    // MEM-stage result bundle at the default widths
    typedef struct packed {
        logic                 reg_write;
        logic                 mem_to_reg;
        logic [c_NB_DATA-1:0] mem_data;
        logic [c_NB_DATA-1:0] alu_result;
        logic [c_NB_REG-1:0]  selected_reg;
        logic                 r31_ctrl;
        logic [c_NB_PC-1:0]   pc;
    } mem_wb_payload_t;

endpackage

`default_nettype wire

// File: rtl/pipe_fifo_core.sv
// ============================================================================
// Module   : pipe_fifo_core
// Brief    : Generic DEPTH x WIDTH register FIFO with ready/valid and flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_fifo_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push_valid,
    output logic                         o_push_ready,
    input  logic [WIDTH-1:0]             i_push_data,
    output logic                         o_pop_valid,
    input  logic                         i_pop_ready,
    output logic [WIDTH-1:0]             o_pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // Ready/valid come only from registered occupancy: no input->ready path
    assign o_push_ready = (r_count < c_CNT_W'(DEPTH));
    assign o_pop_valid  = (r_count != '0);
    assign w_push       = i_push_valid & o_push_ready;
    assign w_pop        = o_pop_valid & i_pop_ready;
    assign o_pop_data   = r_mem[r_rd_ptr];
    assign o_count      = r_count;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left unreset; occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage_fifo.sv
// ============================================================================
// Module   : mem_wb_stage_fifo
// Brief    : MEM->WB elastic pipeline stage with flush and r0-write squash.
//            Optional macro MEM_WB_WBMUX_EN adds the resolved WB data/reg ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage_fifo
    import pipeline_pkg::*;
#(
    parameter int NB_DATA = c_NB_DATA,
    parameter int NB_REG  = c_NB_REG,
    parameter int NB_PC   = c_NB_PC,
    parameter int DEPTH   = 2
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_flush,
    input  logic                       i_MEM_valid,
    output logic                       o_MEM_ready,
    input  logic                       i_MEM_reg_write,
    input  logic                       i_MEM_mem_to_reg,
    input  logic [NB_DATA-1:0]         i_MEM_mem_data,
    input  logic [NB_DATA-1:0]         i_MEM_alu_result,
    input  logic [NB_REG-1:0]          i_MEM_selected_reg,
    input  logic                       i_MEM_r31_ctrl,
    input  logic [NB_PC-1:0]           i_MEM_pc,
    output logic                       o_WB_valid,
    input  logic                       i_WB_ready,
    output logic                       o_WB_reg_write,
    output logic                       o_WB_mem_to_reg,
    output logic [NB_DATA-1:0]         o_WB_mem_data,
    output logic [NB_DATA-1:0]         o_WB_alu_result,
    output logic [NB_REG-1:0]          o_WB_selected_reg,
    output logic                       o_WB_r31_ctrl,
    output logic [NB_PC-1:0]           o_WB_pc,
    output logic [$clog2(DEPTH+1)-1:0] o_count
`ifdef MEM_WB_WBMUX_EN
    ,
    output logic [NB_DATA-1:0]         o_WB_write_data,
    output logic [NB_REG-1:0]          o_WB_write_reg
`endif
);

    typedef struct packed {
        logic               reg_write;
        logic               mem_to_reg;
        logic [NB_DATA-1:0] mem_data;
        logic [NB_DATA-1:0] alu_result;
        logic [NB_REG-1:0]  selected_reg;
        logic               r31_ctrl;
        logic [NB_PC-1:0]   pc;
    } payload_t;

    payload_t w_in;
    payload_t w_head;

    // A write to r0 is squashed at entry unless it is a link write to r31
    always_comb begin
        w_in              = '0;
        w_in.reg_write    = i_MEM_reg_write & ((i_MEM_selected_reg != '0) | i_MEM_r31_ctrl);
        w_in.mem_to_reg   = i_MEM_mem_to_reg;
        w_in.mem_data     = i_MEM_mem_data;
        w_in.alu_result   = i_MEM_alu_result;
        w_in.selected_reg = i_MEM_selected_reg;
        w_in.r31_ctrl     = i_MEM_r31_ctrl;
        w_in.pc           = i_MEM_pc;
    end

    pipe_fifo_core #(
        .WIDTH ($bits(payload_t)),
        .DEPTH (DEPTH)
    ) u_core (
        .clk          (i_clock),
        .rst          (i_reset),
        .i_flush      (i_flush),
        .i_push_valid (i_MEM_valid),
        .o_push_ready (o_MEM_ready),
        .i_push_data  (w_in),
        .o_pop_valid  (o_WB_valid),
        .i_pop_ready  (i_WB_ready),
        .o_pop_data   (w_head),
        .o_count      (o_count)
    );

    // Head fields read as zero whenever the head is not valid
    assign o_WB_reg_write    = o_WB_valid & w_head.reg_write;
    assign o_WB_mem_to_reg   = o_WB_valid & w_head.mem_to_reg;
    assign o_WB_r31_ctrl     = o_WB_valid & w_head.r31_ctrl;
    assign o_WB_mem_data     = o_WB_valid ? w_head.mem_data     : '0;
    assign o_WB_alu_result   = o_WB_valid ? w_head.alu_result   : '0;
    assign o_WB_selected_reg = o_WB_valid ? w_head.selected_reg : '0;
    assign o_WB_pc           = o_WB_valid ? w_head.pc           : '0;

`ifdef MEM_WB_WBMUX_EN
    always_comb begin
        o_WB_write_data = '0;
        o_WB_write_reg  = '0;
        if (o_WB_valid) begin
            if (w_head.r31_ctrl) begin
                o_WB_write_data = NB_DATA'(w_head.pc);
                o_WB_write_reg  = NB_REG'(c_REG_LINK);
            end else begin
                o_WB_write_data = w_head.mem_to_reg ? w_head.mem_data : w_head.alu_result;
                o_WB_write_reg  = w_head.selected_reg;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage_fifo.sv
// ============================================================================
// Module   : tb_mem_wb_stage_fifo
// Brief    : Scoreboard bench for mem_wb_stage_fifo (DEPTH=2, default widths).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_stage_fifo;
    import pipeline_pkg::*;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_MEM_valid = 1'b0;
    logic        o_MEM_ready;
    logic        i_MEM_reg_write = 1'b0;
    logic        i_MEM_mem_to_reg = 1'b0;
    logic [31:0] i_MEM_mem_data = '0;
    logic [31:0] i_MEM_alu_result = '0;
    logic [4:0]  i_MEM_selected_reg = '0;
    logic        i_MEM_r31_ctrl = 1'b0;
    logic [31:0] i_MEM_pc = '0;
    logic        o_WB_valid;
    logic        i_WB_ready = 1'b0;
    logic        o_WB_reg_write;
    logic        o_WB_mem_to_reg;
    logic [31:0] o_WB_mem_data;
    logic [31:0] o_WB_alu_result;
    logic [4:0]  o_WB_selected_reg;
    logic        o_WB_r31_ctrl;
    logic [31:0] o_WB_pc;
    logic [1:0]  o_count;
`ifdef MEM_WB_WBMUX_EN
    logic [31:0] o_WB_write_data;
    logic [4:0]  o_WB_write_reg;
`endif

    mem_wb_stage_fifo #(.NB_DATA(32), .NB_REG(5), .NB_PC(32), .DEPTH(2)) dut (
        .i_clock            (i_clock),
        .i_reset            (i_reset),
        .i_flush            (i_flush),
        .i_MEM_valid        (i_MEM_valid),
        .o_MEM_ready        (o_MEM_ready),
        .i_MEM_reg_write    (i_MEM_reg_write),
        .i_MEM_mem_to_reg   (i_MEM_mem_to_reg),
        .i_MEM_mem_data     (i_MEM_mem_data),
        .i_MEM_alu_result   (i_MEM_alu_result),
        .i_MEM_selected_reg (i_MEM_selected_reg),
        .i_MEM_r31_ctrl     (i_MEM_r31_ctrl),
        .i_MEM_pc           (i_MEM_pc),
        .o_WB_valid         (o_WB_valid),
        .i_WB_ready         (i_WB_ready),
        .o_WB_reg_write     (o_WB_reg_write),
        .o_WB_mem_to_reg    (o_WB_mem_to_reg),
        .o_WB_mem_data      (o_WB_mem_data),
        .o_WB_alu_result    (o_WB_alu_result),
        .o_WB_selected_reg  (o_WB_selected_reg),
        .o_WB_r31_ctrl      (o_WB_r31_ctrl),
        .o_WB_pc            (o_WB_pc),
        .o_count            (o_count)
`ifdef MEM_WB_WBMUX_EN
        ,
        .o_WB_write_data    (o_WB_write_data),
        .o_WB_write_reg     (o_WB_write_reg)
`endif
    );

    always #5 i_clock = ~i_clock;

    int              checks = 0;
    int              errors = 0;
    mem_wb_payload_t exp_q[$];
    mem_wb_payload_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    function automatic mem_wb_payload_t mk(input logic rw, input logic m2r, input logic [31:0] mem,
                                           input logic [31:0] alu, input logic [4:0] sel,
                                           input logic r31, input logic [31:0] pc);
        mem_wb_payload_t b;
        b.reg_write = rw; b.mem_to_reg = m2r; b.mem_data = mem; b.alu_result = alu;
        b.selected_reg = sel; b.r31_ctrl = r31; b.pc = pc;
        return b;
    endfunction

    task automatic drive(input mem_wb_payload_t b);
        i_MEM_reg_write    = b.reg_write;
        i_MEM_mem_to_reg   = b.mem_to_reg;
        i_MEM_mem_data     = b.mem_data;
        i_MEM_alu_result   = b.alu_result;
        i_MEM_selected_reg = b.selected_reg;
        i_MEM_r31_ctrl     = b.r31_ctrl;
        i_MEM_pc           = b.pc;
    endtask

    // Offer a bundle until accepted; the expected entry carries the hand-given reg_write
    task automatic push(input mem_wb_payload_t b, input logic exp_rw);
        mem_wb_payload_t e;
        logic rdy;
        bit   done;
        e = b;
        e.reg_write = exp_rw;
        done = 0;
        drive(b);
        i_MEM_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge i_clock);
            rdy = o_MEM_ready;
            @(posedge i_clock);
            if (rdy) begin
                exp_q.push_back(e);
                done = 1;
            end
        end
        #1 i_MEM_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL push_timeout: got not-accepted, want accepted");
        end
    endtask

    task automatic drain();
        i_WB_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge i_clock); #1;
            if (o_count == 2'd0) break;
        end
        chk("drain_count", o_count, 0);
    endtask

    // Monitor: every WB handshake pops the next expected bundle
    always @(negedge i_clock) begin
        if (!i_reset && !i_flush) begin
            if (o_WB_valid && i_WB_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pop: got alu 0x%0h, want no transfer", o_WB_alu_result);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wb_reg_write",  o_WB_reg_write,    mon_e.reg_write);
                    chk("wb_mem_to_reg", o_WB_mem_to_reg,   mon_e.mem_to_reg);
                    chk("wb_mem_data",   o_WB_mem_data,     mon_e.mem_data);
                    chk("wb_alu_result", o_WB_alu_result,   mon_e.alu_result);
                    chk("wb_sel_reg",    o_WB_selected_reg, mon_e.selected_reg);
                    chk("wb_r31_ctrl",   o_WB_r31_ctrl,     mon_e.r31_ctrl);
                    chk("wb_pc",         o_WB_pc,           mon_e.pc);
                end
            end else if (!o_WB_valid) begin
                chk("invalid_head_reg_write", o_WB_reg_write, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge i_clock);
        #1;
        chk("reset_count",     o_count, 0);
        chk("reset_valid",     o_WB_valid, 0);
        chk("reset_reg_write", o_WB_reg_write, 0);
        chk("reset_ready",     o_MEM_ready, 1);
        chk("reset_alu",       o_WB_alu_result, 0);
        i_reset = 1'b0;

        // Single push, one-cycle latency
        i_WB_ready = 1'b1;
        push(mk(1'b1, 1'b0, 32'h0, 32'h1234, 5'd5, 1'b0, 32'h0), 1'b1);
        chk("t1_valid",     o_WB_valid, 1);
        chk("t1_alu",       o_WB_alu_result, 32'h1234);
        chk("t1_reg_write", o_WB_reg_write, 1);
        chk("t1_count",     o_count, 1);
        @(posedge i_clock); #1;
        chk("t1_valid_after", o_WB_valid, 0);
        chk("t1_count_after", o_count, 0);

        // Back-pressure: fill, hold a third, then release in order
        i_WB_ready = 1'b0;
        push(mk(1'b1, 1'b0, 32'h0,    32'h11, 5'd1, 1'b0, 32'h100), 1'b1);
        push(mk(1'b1, 1'b1, 32'hAAAA, 32'h22, 5'd2, 1'b0, 32'h104), 1'b1);
        chk("t2_ready_full", o_MEM_ready, 0);
        chk("t2_count_full", o_count, 2);
        fork
            push(mk(1'b1, 1'b0, 32'h0, 32'h33, 5'd3, 1'b0, 32'h108), 1'b1);
            begin
                repeat (2) @(posedge i_clock);
                #1;
                chk("t2_ready_held", o_MEM_ready, 0);
                chk("t2_head_alu",   o_WB_alu_result, 32'h11);
                i_WB_ready = 1'b1;
                @(posedge i_clock); #1;
                chk("t2_count_after_pop", o_count, 1);
                chk("t2_ready_freed",     o_MEM_ready, 1);
            end
        join
        drain();

        // r0 write squash and link-write exception
        i_WB_ready = 1'b1;
        push(mk(1'b1, 1'b0, 32'h0, 32'h55, 5'd0, 1'b0, 32'h0), 1'b0);
        chk("t3_sel0_reg_write", o_WB_reg_write, 0);
        push(mk(1'b1, 1'b0, 32'h0,    32'h66, 5'd0, 1'b1, 32'h40), 1'b1);
        push(mk(1'b1, 1'b1, 32'hBEEF, 32'h77, 5'd7, 1'b0, 32'h0),  1'b1);
        push(mk(1'b0, 1'b0, 32'h0,    32'h88, 5'd9, 1'b0, 32'h0),  1'b0);
        drain();

        // Flush with two held and a concurrent push request
        i_WB_ready = 1'b0;
        push(mk(1'b1, 1'b0, 32'h0, 32'hA1, 5'd10, 1'b0, 32'h0), 1'b1);
        push(mk(1'b1, 1'b0, 32'h0, 32'hA2, 5'd11, 1'b0, 32'h0), 1'b1);
        i_flush = 1'b1;
        drive(mk(1'b1, 1'b0, 32'h0, 32'hA3, 5'd12, 1'b0, 32'h0));
        i_MEM_valid = 1'b1;
        @(posedge i_clock); #1;
        i_flush = 1'b0; i_MEM_valid = 1'b0;
        exp_q.delete();
        chk("t4_count", o_count, 0);
        chk("t4_valid", o_WB_valid, 0);
        chk("t4_ready", o_MEM_ready, 1);
        // One held, push that would be accepted, flush still wins
        push(mk(1'b1, 1'b0, 32'h0, 32'hB1, 5'd13, 1'b0, 32'h0), 1'b1);
        i_flush = 1'b1;
        drive(mk(1'b1, 1'b0, 32'h0, 32'hB2, 5'd14, 1'b0, 32'h0));
        i_MEM_valid = 1'b1;
        @(posedge i_clock); #1;
        i_flush = 1'b0; i_MEM_valid = 1'b0;
        exp_q.delete();
        chk("t4b_count", o_count, 0);
        repeat (2) @(posedge i_clock);
        #1;
        chk("t4b_dropped_valid", o_WB_valid, 0);

        // Reset mid-stream with WB ready
        push(mk(1'b1, 1'b0, 32'h0, 32'hC1, 5'd15, 1'b0, 32'h0), 1'b1);
        push(mk(1'b1, 1'b0, 32'h0, 32'hC2, 5'd16, 1'b0, 32'h0), 1'b1);
        i_reset = 1'b1;
        i_WB_ready = 1'b1;
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        exp_q.delete();
        chk("t5_count",     o_count, 0);
        chk("t5_reg_write", o_WB_reg_write, 0);
        chk("t5_ready",     o_MEM_ready, 1);
        chk("t5_valid",     o_WB_valid, 0);

`ifdef MEM_WB_WBMUX_EN
        // Writeback mux selection
        i_WB_ready = 1'b0;
        push(mk(1'b1, 1'b0, 32'h0, 32'h99, 5'd4, 1'b1, 32'h40), 1'b1);
        chk("t6_link_data", o_WB_write_data, 32'h40);
        chk("t6_link_reg",  o_WB_write_reg, 31);
        drain();
        i_WB_ready = 1'b0;
        push(mk(1'b1, 1'b1, 32'hBEEF, 32'h12, 5'd6, 1'b0, 32'h0), 1'b1);
        chk("t6_mem_data", o_WB_write_data, 32'hBEEF);
        chk("t6_mem_reg",  o_WB_write_reg, 6);
        drain();
        chk("t6_idle_data", o_WB_write_data, 0);
        chk("t6_idle_reg",  o_WB_write_reg, 0);
`endif

        chk("queue_consumed", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
